wb_port_adapter: RTL and testbench
==================================

# wb_port_adapter

Parametrised bridge between N narrow LC-3b requesters (instruction fetch, data memory, …) and a single wide Wishbone master port. It replaces per-port glue logic with one shared bus master. The adapter arbitrates requesters round-robin and steers word data and byte enables into and out of line-wide bus transfers. An optional one-line read buffer serves repeated reads to the same line without a bus cycle.

## Interface
- NUM_PORTS, 2, number of requesters (≥1)
- WORD_WIDTH, 16, requester data width (power of 2, ≥8)
- LINE_WIDTH, 128, Wishbone data width (multiple of WORD_WIDTH)
- ADDR_WIDTH, 16, requester byte-address width
- BUFFER_EN, 1, 1 = last-read-line buffer present, 0 = every access goes to the bus
- Derived: OFS = log2(LINE_WIDTH/8); WB = log2(WORD_WIDTH/8)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_read  in  [NUM_PORTS]  read request, held until resp
- req_write  in  [NUM_PORTS]  write request, held until resp
- req_addr  in  [NUM_PORTS][ADDR_WIDTH]  byte address
- req_wdata  in  [NUM_PORTS][WORD_WIDTH]  write data
- req_byte_en  in  [NUM_PORTS][WORD_WIDTH/8]  write byte enables
- req_rdata  out  [NUM_PORTS][WORD_WIDTH]  read data, valid with resp
- req_resp  out  [NUM_PORTS]  one-cycle completion pulse
- wb_cyc, wb_stb, wb_we  out  1 each  Wishbone cycle, strobe, write enable
- wb_adr  out  ADDR_WIDTH-OFS  line address = req_addr[ADDR_WIDTH-1:OFS]
- wb_dat_m  out  LINE_WIDTH  write data
- wb_sel  out  LINE_WIDTH/8  byte selects
- wb_dat_s  in  LINE_WIDTH  read data
- wb_ack  in  1  transfer acknowledge

## Operation
- FSM: IDLE, BUS, RESP.
- IDLE: select the first active port starting from rr_ptr, skipping any masked port.
  - Read hitting a valid buffer (same line address, BUFFER_EN=1) → RESP; no bus cycle.
  - Otherwise latch port, address, word and sel, assert registered wb_cyc=wb_stb=1 and wb_we=write → BUS.
- BUS: hold all wb outputs stable until wb_ack.
  - On wb_ack: drop cyc/stb/we.
  - On a read, capture wb_dat_s into the buffer (tag = line address, valid=1) and extract the word.
  - → RESP.
- RESP: pulse req_resp[granted] for one cycle with req_rdata[granted] driven; rr_ptr ← (granted+1) mod NUM_PORTS; mask granted port for the next IDLE cycle; → IDLE.
- Word index = req_addr[OFS-1:WB].
- Write steering:
  - wb_dat_m = req_wdata replicated into every word slot.
  - wb_sel = req_byte_en shifted to word index × (WORD_WIDTH/8); all other sel bits are 0.
- Read: req_rdata = selected line word; byte enables are ignored.
- Write whose line address matches the buffer tag: buffer valid←0 at ACK.
- req_read and req_write both high on one port: treated as write.
- Requests from non-granted ports wait; no starvation, because the pointer rotates.
- req_rdata of non-granted ports holds its last value.
- wb_ack outside BUS is ignored.

## Timing
- Reset values:
  - All outputs 0: wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_m, wb_sel, req_resp, req_rdata.
  - Internal: rr_ptr=0, buffer valid=0, FSM=IDLE, mask clear.
- Bus read/write: request at cycle 0 → cyc/stb high from cycle 1 → ACK at cycle k≥1 → req_resp at cycle k+1.
- Buffer hit: request at cycle 0 → req_resp at cycle 1.
- Requesters deassert in the cycle after resp. The one-cycle mask prevents double service.
- Reset mid-BUS: cyc/stb drop at the next edge; buffer invalidated; no resp issued.

## Structure
- Shared package lc3b_types gains lc3b_line (LINE_WIDTH vector) and lc3b_line_sel (LINE_WIDTH/8 vector) alongside the existing lc3b_word.
- One sub-module: rr_arbiter (NUM_PORTS requests, pointer, mask in; one-hot grant out, combinational), instantiated once.
- Steering, buffer and FSM live in wb_port_adapter.

## Test plan
- Port 1 read 0x1236, miss, ACK 3 cycles after stb; wb_dat_s word3=16'hBEEF → wb_adr=12'h123, wb_we=0, req_resp[1] one cycle after ACK, req_rdata[1]=16'hBEEF.
- Port 1 read 0x1230 next → hit, no wb_cyc, req_resp[1] at cycle 1 with word0 of the same line.
- Port 0 write 0x0041, byte_en 2'b10, wdata 16'hAB00 → wb_we=1, wb_adr=12'h004, wb_sel=16'h0002, wb_dat_m[15:8]=8'hAB; resp after ACK.
- Write to the buffered line, then a read of it → buffer invalidated; read goes to the bus.
- Both ports request continuously → grants alternate 0,1,0,1; each resp is exactly one cycle.
- rst_n low during BUS → cyc/stb 0 next edge; late wb_ack ignored; all outputs at reset values.

Source files
------------

// File: rtl/wb_port_adapter_pkg.sv
// Shared LC-3b types plus adapter FSM encoding and sizing helper.
package wb_port_adapter_pkg;

  localparam int unsigned LC3B_WORD_WIDTH = 16;
  localparam int unsigned LC3B_LINE_WIDTH = 128;

  typedef logic [LC3B_WORD_WIDTH-1:0]   lc3b_word;
  typedef logic [LC3B_LINE_WIDTH-1:0]   lc3b_line;
  typedef logic [LC3B_LINE_WIDTH/8-1:0] lc3b_line_sel;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } adapter_state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_port_adapter_if.sv
// Wide Wishbone master port shared by all requesters.
interface wb_port_adapter_if #(
  parameter int unsigned ADR_W  = 12,
  parameter int unsigned LINE_W = 128
);

  localparam int unsigned SEL_W = LINE_W / 8;

  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [ADR_W-1:0]  wb_adr;
  logic [LINE_W-1:0] wb_dat_m;
  logic [SEL_W-1:0]  wb_sel;
  logic [LINE_W-1:0] wb_dat_s;
  logic              wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_m, wb_sel,
    input  wb_dat_s, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_m, wb_sel,
    output wb_dat_s, wb_ack
  );

endinterface

// File: rtl/wb_port_adapter_rr_arbiter.sv
// Round-robin requester arbiter: one-hot grant, combinational.
module wb_port_adapter_rr_arbiter
  import wb_port_adapter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PW        = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [NUM_PORTS-1:0] i_mask,
  input  logic [PW-1:0]        i_ptr,
  output logic [NUM_PORTS-1:0] o_gnt_c
);

  logic w_found;

  // Scan ports starting at the pointer; first unmasked active port wins.
  always_comb begin
    o_gnt_c = '0;
    w_found = 1'b0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        if (((int'(i_ptr) + i) % int'(NUM_PORTS)) == p) begin
          if (!w_found && i_req[p] && !i_mask[p]) begin
            o_gnt_c[p] = 1'b1;
            w_found    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/wb_port_adapter.sv
// Bridges N narrow LC-3b requesters onto one wide Wishbone master,
// with an optional last-read-line buffer.
module wb_port_adapter
  import wb_port_adapter_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter bit          BUFFER_EN  = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_PORTS-1:0]                   req_read,
  input  logic [NUM_PORTS-1:0]                   req_write,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS-1:0][WORD_WIDTH-1:0]   req_wdata,
  input  logic [NUM_PORTS-1:0][WORD_WIDTH/8-1:0] req_byte_en,
  output logic [NUM_PORTS-1:0][WORD_WIDTH-1:0]   req_rdata,
  output logic [NUM_PORTS-1:0]                   req_resp,
  wb_port_adapter_if.master                      wb
);

  localparam int unsigned BPW    = WORD_WIDTH / 8;
  localparam int unsigned OFS    = $clog2(LINE_WIDTH / 8);
  localparam int unsigned WB     = $clog2(BPW);
  localparam int unsigned NWORDS = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned IDXW   = idx_width(NWORDS);
  localparam int unsigned LADR_W = ADDR_WIDTH - OFS;
  localparam int unsigned SEL_W  = LINE_WIDTH / 8;
  localparam int unsigned PW     = idx_width(NUM_PORTS);

  adapter_state_e r_state, w_state_nxt;

  // Arbitration state
  logic [PW-1:0]        r_rr_ptr, w_ptr_nxt;
  logic [NUM_PORTS-1:0] r_mask, r_gnt, w_gnt, w_active;

  // Granted-request view
  logic                  w_any;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [WORD_WIDTH-1:0] w_sel_wdata;
  logic [BPW-1:0]        w_sel_be;
  logic                  w_sel_wr;
  logic [LADR_W-1:0]     w_line_adr;
  logic [IDXW-1:0]       w_word_idx;
  logic [SEL_W-1:0]      w_line_sel;
  logic                  w_hit;

  // FSM strobes
  logic w_launch, w_hit_go, w_ack_go;

  // Bus master registers
  logic                  r_cyc, r_stb, r_we;
  logic [LADR_W-1:0]     r_adr;
  logic [LINE_WIDTH-1:0] r_dat_m;
  logic [SEL_W-1:0]      r_sel;
  logic [IDXW-1:0]       r_word_idx;

  // Line buffer
  logic                  r_buf_valid;
  logic [LADR_W-1:0]     r_buf_tag;
  logic [LINE_WIDTH-1:0] r_buf_line;
  logic [WORD_WIDTH-1:0] w_buf_word, w_ack_word;

  // Response registers
  logic [NUM_PORTS-1:0]                 r_resp;
  logic [NUM_PORTS-1:0][WORD_WIDTH-1:0] r_rdata;

  assign w_active = req_read | req_write;
  assign w_any    = |w_gnt;

  wb_port_adapter_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_arb (
    .i_req   (w_active),
    .i_mask  (r_mask),
    .i_ptr   (r_rr_ptr),
    .o_gnt_c (w_gnt)
  );

  // Mux the granted requester's fields (write wins over read).
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    w_sel_wr    = 1'b0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (w_gnt[p]) begin
        w_sel_addr  = req_addr[p];
        w_sel_wdata = req_wdata[p];
        w_sel_be    = req_byte_en[p];
        w_sel_wr    = req_write[p];
      end
    end
  end

  assign w_line_adr = LADR_W'(w_sel_addr >> OFS);
  assign w_word_idx = (NWORDS == 1) ? '0 : IDXW'(w_sel_addr >> WB);
  assign w_hit      = BUFFER_EN && r_buf_valid && !w_sel_wr && (w_line_adr == r_buf_tag);

  // Place the word's byte enables into its slot of the line select.
  always_comb begin
    w_line_sel = '0;
    for (int w = 0; w < int'(NWORDS); w++) begin
      if (w_word_idx == IDXW'(w)) begin
        w_line_sel[w*BPW +: BPW] = w_sel_be;
      end
    end
  end

  // Pick the addressed word out of the buffered line and the acked line.
  always_comb begin
    w_buf_word = '0;
    w_ack_word = '0;
    for (int w = 0; w < int'(NWORDS); w++) begin
      if (w_word_idx == IDXW'(w)) begin
        w_buf_word = r_buf_line[w*WORD_WIDTH +: WORD_WIDTH];
      end
      if (r_word_idx == IDXW'(w)) begin
        w_ack_word = wb.wb_dat_s[w*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Pointer advances to the port after the one just served.
  always_comb begin
    w_ptr_nxt = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (r_gnt[p]) begin
        w_ptr_nxt = (p == int'(NUM_PORTS) - 1) ? '0 : PW'(p + 1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state and transition strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_hit_go    = 1'b0;
    w_ack_go    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          if (w_hit) begin
            w_hit_go    = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_launch    = 1'b1;
            w_state_nxt = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (wb.wb_ack) begin
          w_ack_go    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant bookkeeping: rotate pointer and mask the served port for one IDLE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_mask   <= '0;
      r_gnt    <= '0;
    end else begin
      if (w_launch || w_hit_go) r_gnt <= w_gnt;
      if (r_state == S_RESP) begin
        r_rr_ptr <= w_ptr_nxt;
        r_mask   <= r_gnt;
      end else if (r_state == S_IDLE) begin
        r_mask <= '0;
      end
    end
  end

  // Wishbone master: launch a line transfer, hold until ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_dat_m    <= '0;
      r_sel      <= '0;
      r_word_idx <= '0;
    end else if (w_launch) begin
      r_cyc      <= 1'b1;
      r_stb      <= 1'b1;
      r_we       <= w_sel_wr;
      r_adr      <= w_line_adr;
      r_dat_m    <= {NWORDS{w_sel_wdata}};
      r_sel      <= w_line_sel;
      r_word_idx <= w_word_idx;
    end else if (w_ack_go) begin
      r_cyc <= 1'b0;
      r_stb <= 1'b0;
      r_we  <= 1'b0;
    end
  end

  // Line buffer: fill on read ack, invalidate on a write to the same line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_line  <= '0;
    end else if (BUFFER_EN && w_ack_go) begin
      if (!r_we) begin
        r_buf_valid <= 1'b1;
        r_buf_tag   <= r_adr;
        r_buf_line  <= wb.wb_dat_s;
      end else if (r_adr == r_buf_tag) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

  // Completion pulse and read data for the served port; others hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resp  <= '0;
      r_rdata <= '0;
    end else begin
      r_resp <= '0;
      if (w_hit_go) begin
        r_resp <= w_gnt;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
          if (w_gnt[p]) r_rdata[p] <= w_buf_word;
        end
      end else if (w_ack_go) begin
        r_resp <= r_gnt;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
          if (r_gnt[p] && !r_we) r_rdata[p] <= w_ack_word;
        end
      end
    end
  end

  assign wb.wb_cyc   = r_cyc;
  assign wb.wb_stb   = r_stb;
  assign wb.wb_we    = r_we;
  assign wb.wb_adr   = r_adr;
  assign wb.wb_dat_m = r_dat_m;
  assign wb.wb_sel   = r_sel;
  assign req_resp    = r_resp;
  assign req_rdata   = r_rdata;

endmodule

// File: tb/tb_wb_port_adapter.sv
// Directed self-checking bench for wb_port_adapter (2 ports, 16-bit words, 128-bit lines).
module tb_wb_port_adapter;

  localparam logic [127:0] LINE_A  = 128'h7777_6666_5555_4444_BEEF_2222_1111_C0DE;
  localparam logic [127:0] LINE_B  = 128'h0000_0000_0000_0000_0000_0000_0000_9999;
  localparam logic [127:0] LINE_RR = 128'h0000_0000_0000_0000_0000_0000_0B0B_0A0A;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           req_read;
  logic [1:0]           req_write;
  logic [1:0][15:0]     req_addr;
  logic [1:0][15:0]     req_wdata;
  logic [1:0][1:0]      req_byte_en;
  logic [1:0][15:0]     req_rdata;
  logic [1:0]           req_resp;

  int tests_run;
  int tests_failed;

  wb_port_adapter_if #(.ADR_W(12), .LINE_W(128)) wb_bus ();

  wb_port_adapter #(
    .NUM_PORTS  (2),
    .WORD_WIDTH (16),
    .LINE_WIDTH (128),
    .ADDR_WIDTH (16),
    .BUFFER_EN  (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_byte_en (req_byte_en),
    .req_rdata   (req_rdata),
    .req_resp    (req_resp),
    .wb          (wb_bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++; if (wb_bus.wb_cyc !== 1'b0) begin tests_failed++; $display("FAIL reset_cyc got %b want 0", wb_bus.wb_cyc); end
    tests_run++; if (wb_bus.wb_stb !== 1'b0) begin tests_failed++; $display("FAIL reset_stb got %b want 0", wb_bus.wb_stb); end
    tests_run++; if (wb_bus.wb_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we got %b want 0", wb_bus.wb_we); end
    tests_run++; if (wb_bus.wb_adr !== 12'h000) begin tests_failed++; $display("FAIL reset_adr got %h want 000", wb_bus.wb_adr); end
    tests_run++; if (wb_bus.wb_dat_m !== 128'h0) begin tests_failed++; $display("FAIL reset_dat_m got %h want 0", wb_bus.wb_dat_m); end
    tests_run++; if (wb_bus.wb_sel !== 16'h0000) begin tests_failed++; $display("FAIL reset_sel got %h want 0000", wb_bus.wb_sel); end
    tests_run++; if (req_resp !== 2'b00) begin tests_failed++; $display("FAIL reset_resp got %b want 00", req_resp); end
    tests_run++; if (req_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata got %h want 0", req_rdata); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_miss();
    tick();
    req_read[1] = 1'b1;
    req_addr[1] = 16'h1236;
    tick();
    tests_run++; if (wb_bus.wb_cyc !== 1'b1 || wb_bus.wb_stb !== 1'b1) begin tests_failed++; $display("FAIL miss_cycstb got %b%b want 11", wb_bus.wb_cyc, wb_bus.wb_stb); end
    tests_run++; if (wb_bus.wb_we !== 1'b0) begin tests_failed++; $display("FAIL miss_we got %b want 0", wb_bus.wb_we); end
    tests_run++; if (wb_bus.wb_adr !== 12'h123) begin tests_failed++; $display("FAIL miss_adr got %h want 123", wb_bus.wb_adr); end
    tick();
    tick();
    tests_run++; if (wb_bus.wb_cyc !== 1'b1 || req_resp !== 2'b00) begin tests_failed++; $display("FAIL miss_hold got cyc=%b resp=%b want cyc=1 resp=00", wb_bus.wb_cyc, req_resp); end
    tick();
    wb_bus.wb_ack   = 1'b1;
    wb_bus.wb_dat_s = LINE_A;
    tick();
    wb_bus.wb_ack = 1'b0;
    tests_run++; if (req_resp !== 2'b10) begin tests_failed++; $display("FAIL miss_resp got %b want 10", req_resp); end
    tests_run++; if (req_rdata[1] !== 16'hBEEF) begin tests_failed++; $display("FAIL miss_rdata got %h want beef", req_rdata[1]); end
    tests_run++; if (wb_bus.wb_cyc !== 1'b0 || wb_bus.wb_stb !== 1'b0) begin tests_failed++; $display("FAIL miss_drop got %b%b want 00", wb_bus.wb_cyc, wb_bus.wb_stb); end
    req_read[1] = 1'b0;
    tick();
    tests_run++; if (req_resp !== 2'b00) begin tests_failed++; $display("FAIL miss_pulse got %b want 00", req_resp); end
  endtask

  task automatic test_read_hit();
    tick();
    req_read[1] = 1'b1;
    req_addr[1] = 16'h1230;
    tick();
    tests_run++; if (req_resp !== 2'b10) begin tests_failed++; $display("FAIL hit_resp got %b want 10", req_resp); end
    tests_run++; if (req_rdata[1] !== 16'hC0DE) begin tests_failed++; $display("FAIL hit_rdata got %h want c0de", req_rdata[1]); end
    tests_run++; if (wb_bus.wb_cyc !== 1'b0) begin tests_failed++; $display("FAIL hit_nocyc got %b want 0", wb_bus.wb_cyc); end
    req_read[1] = 1'b0;
    tick();
    tests_run++; if (req_resp !== 2'b00 || wb_bus.wb_cyc !== 1'b0) begin tests_failed++; $display("FAIL hit_after got resp=%b cyc=%b want 00/0", req_resp, wb_bus.wb_cyc); end
  endtask

  task automatic test_write();
    tick();
    req_write[0]   = 1'b1;
    req_addr[0]    = 16'h0041;
    req_byte_en[0] = 2'b10;
    req_wdata[0]   = 16'hAB00;
    tick();
    tests_run++; if (wb_bus.wb_we !== 1'b1 || wb_bus.wb_cyc !== 1'b1) begin tests_failed++; $display("FAIL wr_we got we=%b cyc=%b want 1/1", wb_bus.wb_we, wb_bus.wb_cyc); end
    tests_run++; if (wb_bus.wb_adr !== 12'h004) begin tests_failed++; $display("FAIL wr_adr got %h want 004", wb_bus.wb_adr); end
    tests_run++; if (wb_bus.wb_sel !== 16'h0002) begin tests_failed++; $display("FAIL wr_sel got %h want 0002", wb_bus.wb_sel); end
    tests_run++; if (wb_bus.wb_dat_m !== 128'hAB00_AB00_AB00_AB00_AB00_AB00_AB00_AB00) begin tests_failed++; $display("FAIL wr_dat_m got %h want ab00 x8", wb_bus.wb_dat_m); end
    wb_bus.wb_ack = 1'b1;
    tick();
    wb_bus.wb_ack = 1'b0;
    tests_run++; if (req_resp !== 2'b01) begin tests_failed++; $display("FAIL wr_resp got %b want 01", req_resp); end
    tests_run++; if (req_rdata[1] !== 16'hC0DE) begin tests_failed++; $display("FAIL wr_hold_rdata1 got %h want c0de", req_rdata[1]); end
    tick();
    tests_run++; if (req_resp !== 2'b00 || wb_bus.wb_cyc !== 1'b0) begin tests_failed++; $display("FAIL wr_idle got resp=%b cyc=%b want 00/0", req_resp, wb_bus.wb_cyc); end
    tick();
    tests_run++; if (wb_bus.wb_cyc !== 1'b0) begin tests_failed++; $display("FAIL wr_mask got cyc=%b want 0", wb_bus.wb_cyc); end
    req_write[0] = 1'b0;
    tick();
  endtask

  task automatic test_write_invalidate();
    tick();
    req_write[0]   = 1'b1;
    req_addr[0]    = 16'h1234;
    req_byte_en[0] = 2'b11;
    req_wdata[0]   = 16'h5A5A;
    tick();
    tests_run++; if (wb_bus.wb_sel !== 16'h0030) begin tests_failed++; $display("FAIL inv_sel got %h want 0030", wb_bus.wb_sel); end
    tests_run++; if (wb_bus.wb_dat_m !== 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A) begin tests_failed++; $display("FAIL inv_dat_m got %h want 5a5a x8", wb_bus.wb_dat_m); end
    wb_bus.wb_ack = 1'b1;
    tick();
    wb_bus.wb_ack = 1'b0;
    tests_run++; if (req_resp !== 2'b01) begin tests_failed++; $display("FAIL inv_wr_resp got %b want 01", req_resp); end
    req_write[0] = 1'b0;
    tick();
    tick();
    req_read[1] = 1'b1;
    req_addr[1] = 16'h1230;
    tick();
    tests_run++; if (wb_bus.wb_cyc !== 1'b1 || wb_bus.wb_adr !== 12'h123 || req_resp !== 2'b00) begin tests_failed++; $display("FAIL inv_miss got cyc=%b adr=%h resp=%b want 1/123/00", wb_bus.wb_cyc, wb_bus.wb_adr, req_resp); end
    wb_bus.wb_ack   = 1'b1;
    wb_bus.wb_dat_s = LINE_B;
    tick();
    wb_bus.wb_ack = 1'b0;
    tests_run++; if (req_resp !== 2'b10 || req_rdata[1] !== 16'h9999) begin tests_failed++; $display("FAIL inv_rd got resp=%b rdata=%h want 10/9999", req_resp, req_rdata[1]); end
    req_read[1] = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_resp;
    logic [11:0] exp_adr;
    logic [15:0] exp_data;
    int          waited;
    tick();
    req_read       = 2'b11;
    req_addr[0]    = 16'h2000;
    req_addr[1]    = 16'h3002;
    tick();
    for (int it = 0; it < 4; it++) begin
      exp_resp = (it % 2 == 0) ? 2'b01 : 2'b10;
      exp_adr  = (it % 2 == 0) ? 12'h200 : 12'h300;
      exp_data = (it % 2 == 0) ? 16'h0A0A : 16'h0B0B;
      waited = 0;
      while (wb_bus.wb_cyc !== 1'b1 && waited < 8) begin
        tick();
        waited++;
      end
      tests_run++; if (wb_bus.wb_cyc !== 1'b1) begin tests_failed++; $display("FAIL rr_timeout it=%0d cyc=%b want 1", it, wb_bus.wb_cyc); end
      tests_run++; if (wb_bus.wb_adr !== exp_adr) begin tests_failed++; $display("FAIL rr_adr it=%0d got %h want %h", it, wb_bus.wb_adr, exp_adr); end
      wb_bus.wb_ack   = 1'b1;
      wb_bus.wb_dat_s = LINE_RR;
      tick();
      wb_bus.wb_ack = 1'b0;
      tests_run++; if (req_resp !== exp_resp) begin tests_failed++; $display("FAIL rr_grant it=%0d got %b want %b", it, req_resp, exp_resp); end
      tests_run++; if (req_rdata[(it % 2)] !== exp_data) begin tests_failed++; $display("FAIL rr_rdata it=%0d got %h want %h", it, req_rdata[(it % 2)], exp_data); end
      tick();
      tests_run++; if (req_resp !== 2'b00) begin tests_failed++; $display("FAIL rr_pulse it=%0d got %b want 00", it, req_resp); end
    end
    req_read = 2'b00;
    tick();
    tests_run++; if (wb_bus.wb_cyc !== 1'b0) begin tests_failed++; $display("FAIL rr_quiet got cyc=%b want 0", wb_bus.wb_cyc); end
  endtask

  task automatic test_reset_mid_bus();
    tick();
    req_read[0] = 1'b1;
    req_addr[0] = 16'h4000;
    tick();
    tests_run++; if (wb_bus.wb_cyc !== 1'b1) begin tests_failed++; $display("FAIL mid_start got cyc=%b want 1", wb_bus.wb_cyc); end
    rst_n = 1'b0;
    tick();
    tests_run++; if (wb_bus.wb_cyc !== 1'b0 || wb_bus.wb_stb !== 1'b0) begin tests_failed++; $display("FAIL mid_drop got %b%b want 00", wb_bus.wb_cyc, wb_bus.wb_stb); end
    tests_run++; if (wb_bus.wb_adr !== 12'h000 || wb_bus.wb_sel !== 16'h0000 || wb_bus.wb_dat_m !== 128'h0) begin tests_failed++; $display("FAIL mid_bus_vals got adr=%h sel=%h want 000/0000", wb_bus.wb_adr, wb_bus.wb_sel); end
    tests_run++; if (req_resp !== 2'b00 || req_rdata !== 32'h0) begin tests_failed++; $display("FAIL mid_req_vals got resp=%b rdata=%h want 00/0", req_resp, req_rdata); end
    rst_n         = 1'b1;
    req_read[0]   = 1'b0;
    wb_bus.wb_ack = 1'b1;
    tick();
    tests_run++; if (req_resp !== 2'b00 || wb_bus.wb_cyc !== 1'b0) begin tests_failed++; $display("FAIL mid_late_ack got resp=%b cyc=%b want 00/0", req_resp, wb_bus.wb_cyc); end
    wb_bus.wb_ack = 1'b0;
    tick();
    req_read[1] = 1'b1;
    req_addr[1] = 16'h3002;
    tick();
    tests_run++; if (wb_bus.wb_cyc !== 1'b1 || req_resp !== 2'b00) begin tests_failed++; $display("FAIL mid_buf_inval got cyc=%b resp=%b want 1/00", wb_bus.wb_cyc, req_resp); end
    wb_bus.wb_ack   = 1'b1;
    wb_bus.wb_dat_s = LINE_RR;
    tick();
    wb_bus.wb_ack = 1'b0;
    tests_run++; if (req_resp !== 2'b10 || req_rdata[1] !== 16'h0B0B) begin tests_failed++; $display("FAIL mid_reread got resp=%b rdata=%h want 10/0b0b", req_resp, req_rdata[1]); end
    req_read[1] = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clk             = 1'b0;
    rst_n           = 1'b0;
    req_read        = '0;
    req_write       = '0;
    req_addr        = '0;
    req_wdata       = '0;
    req_byte_en     = '0;
    wb_bus.wb_ack   = 1'b0;
    wb_bus.wb_dat_s = '0;
    tests_run       = 0;
    tests_failed    = 0;

    test_reset();
    test_read_miss();
    test_read_hit();
    test_write();
    test_write_invalidate();
    test_back_to_back();
    test_reset_mid_bus();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
